// File: rtl/rc4_key_search_ctrl.sv
// Brute-force RC4 key search sequencer: launches one datapath run per candidate key,
// then scans decrypted D memory for lowercase/space plaintext.
module rc4_key_search_ctrl #(
    parameter int KEY_WIDTH = 10,
    parameter int KEY_LO    = 0,
    parameter int KEY_HI    = 2**KEY_WIDTH - 1,
    parameter int MSG_LEN   = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 search_start,
    input  logic                 abort,
    output logic                 dp_start,
    output logic [KEY_WIDTH-1:0] dp_key,
    input  logic                 dp_done,
    output logic                 dp_done_ack,
    output logic [4:0]           d_rd_addr,
    input  logic [7:0]           d_rd_data,
    output logic                 busy,
    output logic                 found,
    output logic                 exhausted,
    output logic [KEY_WIDTH-1:0] found_key
);

    // state       | meaning
    // S_IDLE      | waiting for search_start
    // S_LAUNCH    | dp_start pulse cycle
    // S_WAIT_DP   | datapath running, waiting for dp_done
    // S_CHECK     | scanning D memory, one byte per cycle
    // S_NEXT_KEY  | advance key or declare exhaustion
    // S_ABORT_DRAIN | aborted, waiting for in-flight run to finish
    // S_FOUND     | valid key held in found_key
    // S_EXHAUSTED | KEY_HI rejected

    localparam int IDX_W = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam logic [KEY_WIDTH-1:0] KEY_LO_V  = KEY_WIDTH'(KEY_LO);
    localparam logic [KEY_WIDTH-1:0] KEY_HI_V  = KEY_WIDTH'(KEY_HI);
    localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(MSG_LEN - 1);
    localparam logic [4:0]           LAST_ADDR = 5'(MSG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT_DP, S_CHECK,
        S_NEXT_KEY, S_ABORT_DRAIN, S_FOUND, S_EXHAUSTED
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] chk_idx;
    logic             chk_armed;
    logic             byte_ok;

    assign byte_ok = ((d_rd_data >= 8'h61) && (d_rd_data <= 8'h7A)) || (d_rd_data == 8'h20);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            dp_start    <= 1'b0;
            dp_key      <= KEY_LO_V;
            dp_done_ack <= 1'b0;
            d_rd_addr   <= 5'd0;
            busy        <= 1'b0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            found_key   <= '0;
            chk_idx     <= '0;
            chk_armed   <= 1'b0;
        end else begin
            dp_start    <= 1'b0;
            dp_done_ack <= 1'b0;
            case (state)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (!abort && search_start) begin
                        found     <= 1'b0;
                        exhausted <= 1'b0;
                        dp_key    <= KEY_LO_V;
                        dp_start  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_LAUNCH;
                    end
                end
                // An abort here still has a run in flight, so it must be drained.
                S_LAUNCH: state <= abort ? S_ABORT_DRAIN : S_WAIT_DP;
                S_WAIT_DP: begin
                    if (abort) begin
                        state <= S_ABORT_DRAIN;
                    end else if (dp_done) begin
                        dp_done_ack <= 1'b1;
                        d_rd_addr   <= 5'd0;
                        chk_idx     <= '0;
                        chk_armed   <= 1'b0;
                        state       <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (d_rd_addr < LAST_ADDR)
                            d_rd_addr <= d_rd_addr + 5'd1;
                        chk_armed <= 1'b1;
                        // Read data lags the address by one cycle; the entry cycle has nothing to compare.
                        if (chk_armed) begin
                            if (!byte_ok) begin
                                state <= S_NEXT_KEY;
                            end else if (chk_idx == LAST_IDX) begin
                                found     <= 1'b1;
                                found_key <= dp_key;
                                busy      <= 1'b0;
                                state     <= S_FOUND;
                            end else begin
                                chk_idx <= chk_idx + IDX_W'(1);
                            end
                        end
                    end
                end
                S_NEXT_KEY: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (dp_key == KEY_HI_V) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_EXHAUSTED;
                    end else begin
                        dp_key   <= dp_key + KEY_WIDTH'(1);
                        dp_start <= 1'b1;
                        state    <= S_LAUNCH;
                    end
                end
                S_ABORT_DRAIN: begin
                    if (dp_done) begin
                        dp_done_ack <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with a behavioural datapath and D-memory model.
module tb_rc4_key_search_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       search_start;
    logic       abort;
    logic       dp_start;
    logic [9:0] dp_key;
    logic       dp_done;
    logic       dp_done_ack;
    logic [4:0] d_rd_addr;
    logic [7:0] d_rd_data;
    logic       busy;
    logic       found;
    logic       exhausted;
    logic [9:0] found_key;

    int checks = 0;
    int errors = 0;

    rc4_key_search_ctrl #(.KEY_WIDTH(10), .KEY_LO(0), .KEY_HI(7), .MSG_LEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .search_start(search_start), .abort(abort),
        .dp_start(dp_start), .dp_key(dp_key), .dp_done(dp_done), .dp_done_ack(dp_done_ack),
        .d_rd_addr(d_rd_addr), .d_rd_data(d_rd_data), .busy(busy), .found(found),
        .exhausted(exhausted), .found_key(found_key)
    );

    always #5 clk = ~clk;

    // Datapath / memory model configuration
    logic [7:0] mem [32];
    int         good_key = 3;
    bit         all_same = 1'b0;
    int         dp_lat   = 5;
    int         dp_cnt   = 0;
    bit         dp_run   = 1'b0;
    int         n_start  = 0;
    int         n_ack    = 0;
    int         max_key  = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dp_done <= 1'b0;
            dp_run  <= 1'b0;
            dp_cnt  <= 0;
        end else begin
            if (dp_done_ack) dp_done <= 1'b0;
            if (dp_start) begin
                dp_run <= 1'b1;
                dp_cnt <= dp_lat;
            end else if (dp_run) begin
                if (dp_cnt == 0) begin
                    dp_done <= 1'b1;
                    dp_run  <= 1'b0;
                end else begin
                    dp_cnt <= dp_cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (!all_same && (int'(dp_key) != good_key) && (d_rd_addr == 5'd0))
            d_rd_data <= 8'h7B;
        else
            d_rd_data <= mem[d_rd_addr];
        if (dp_start)    n_start <= n_start + 1;
        if (dp_done_ack) n_ack   <= n_ack + 1;
        if (int'(dp_key) > max_key) max_key <= int'(dp_key);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) search_start = 1'b1;
        @(negedge clk) search_start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) @(negedge clk);
    endtask

    int s0, a0;
    logic [7:0] bvals [7];
    bit         bgood [7];

    initial begin
        string s = "the quick brown fox jumps over t";
        for (int i = 0; i < 32; i++) mem[i] = s[i];
        bvals = '{8'h60, 8'h7B, 8'h1F, 8'h21, 8'h61, 8'h7A, 8'h20};
        bgood = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        reset_n = 1'b0; search_start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_found", 32'(found), 0);
        chk("rst_exh", 32'(exhausted), 0);
        chk("rst_dp_start", 32'(dp_start), 0);
        chk("rst_ack", 32'(dp_done_ack), 0);
        chk("rst_addr", 32'(d_rd_addr), 0);
        chk("rst_found_key", 32'(found_key), 0);
        chk("rst_dp_key", 32'(dp_key), 0);

        // Find key 3; a search_start while busy must be ignored
        s0 = n_start; a0 = n_ack;
        pulse_start();
        for (int i = 0; i < 1000 && dp_key != 10'd2; i++) @(negedge clk);
        pulse_start();
        wait_idle(2000);
        chk("find_busy", 32'(busy), 0);
        chk("find_found", 32'(found), 1);
        chk("find_key", 32'(found_key), 3);
        chk("find_starts", 32'(n_start - s0), 4);
        chk("find_acks", 32'(n_ack - a0), 4);

        // Restart from FOUND
        @(negedge clk) search_start = 1'b1;
        @(negedge clk) search_start = 1'b0;
        chk("restart_dp_start", 32'(dp_start), 1);
        chk("restart_found", 32'(found), 0);
        chk("restart_dp_key", 32'(dp_key), 0);
        wait_idle(2000);
        chk("restart_found_key", 32'(found_key), 3);

        // Exhaust: no key valid
        good_key = 99;
        s0 = n_start;
        pulse_start();
        wait_idle(4000);
        chk("exh_busy", 32'(busy), 0);
        chk("exh_exhausted", 32'(exhausted), 1);
        chk("exh_found", 32'(found), 0);
        chk("exh_dp_key", 32'(dp_key), 7);
        chk("exh_starts", 32'(n_start - s0), 8);

        // Character boundaries on the last byte
        all_same = 1'b1;
        for (int v = 0; v < 7; v++) begin
            mem[31] = bvals[v];
            pulse_start();
            wait_idle(4000);
            chk($sformatf("char_%02h_found", bvals[v]), 32'(found), 32'(bgood[v]));
            chk($sformatf("char_%02h_exh", bvals[v]), 32'(exhausted), 32'(!bgood[v]));
            if (bgood[v]) chk($sformatf("char_%02h_key", bvals[v]), 32'(found_key), 0);
        end
        mem[31] = 8'h74;
        all_same = 1'b0;

        // Abort while the datapath is running
        dp_lat = 60;
        s0 = n_start; a0 = n_ack;
        pulse_start();
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk) abort = 1'b0;
        chk("abort_draining_busy", 32'(busy), 1);
        repeat (80) @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_acks", 32'(n_ack - a0), 1);
        chk("abort_starts", 32'(n_start - s0), 1);
        chk("abort_found", 32'(found), 0);
        chk("abort_exh", 32'(exhausted), 0);
        chk("abort_dp_done", 32'(dp_done), 0);
        dp_lat = 5;

        chk("max_key", 32'(max_key), 7);

        // Reset in the middle of a search
        pulse_start();
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_dp_key", 32'(dp_key), 0);
        chk("midrst_dp_start", 32'(dp_start), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
